// File: rtl/edge_burst_gen.sv
// edge_burst_gen
//
// Purpose:
//   Emits a burst of N square-wave periods on gen_out. Each period is H' clk
//   cycles high followed by L' cycles low, with H' = max(high_cycles,1) and
//   L' = max(low_cycles,1). A one-cycle done pulse follows the final low phase.
//   burst_len = 0 gives an empty burst: done pulses and gen_out stays low.
//
// Configuration macro:
//   EDGE_COUNT_EN - when defined, pos_count/neg_count count the rising and
//                   falling edges emitted in the current or last burst. When
//                   undefined, both outputs are tied to zero and the counter
//                   logic is not built. Waveform timing is the same either way.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   burst request, sampled only while idle
//   burst_len    in   [CNT_W] number of periods N
//   high_cycles  in   [PER_W] high phase length H
//   low_cycles   in   [PER_W] low phase length L
//   gen_out      out  registered waveform
//   busy         out  high while a burst is in progress
//   done         out  one-cycle completion pulse
//   pos_count    out  [CNT_W] rising edges emitted (wraps)
//   neg_count    out  [CNT_W] falling edges emitted (wraps)

module edge_burst_gen #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [PER_W-1:0] high_cycles,
  input  logic [PER_W-1:0] low_cycles,
  output logic             gen_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos_count,
  output logic [CNT_W-1:0] neg_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [PER_W-1:0] high_len_reg;   // latched H'
  logic [PER_W-1:0] low_len_reg;    // latched L'
  logic [PER_W-1:0] phase_reg;      // cycles left in the current phase, minus one
  logic [CNT_W-1:0] remaining_reg;  // periods left, including the current one

  // Zero-length phases are promoted to one cycle so every period has both edges.
  logic [PER_W-1:0] high_eff;
  logic [PER_W-1:0] low_eff;
  assign high_eff = (high_cycles == '0) ? PER_W'(1) : high_cycles;
  assign low_eff  = (low_cycles  == '0) ? PER_W'(1) : low_cycles;

`ifndef EDGE_COUNT_EN
  assign pos_count = '0;
  assign neg_count = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      high_len_reg  <= PER_W'(1);
      low_len_reg   <= PER_W'(1);
      phase_reg     <= '0;
      remaining_reg <= '0;
      gen_out       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef EDGE_COUNT_EN
      pos_count     <= '0;
      neg_count     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            high_len_reg  <= high_eff;
            low_len_reg   <= low_eff;
            remaining_reg <= burst_len;
`ifdef EDGE_COUNT_EN
            pos_count     <= '0;
            neg_count     <= '0;
`endif
            if (burst_len == '0) begin
              done <= 1'b1;
            end else begin
              gen_out   <= 1'b1;
              busy      <= 1'b1;
              state_reg <= HIGH;
              phase_reg <= high_eff - PER_W'(1);
`ifdef EDGE_COUNT_EN
              pos_count <= CNT_W'(1);
`endif
            end
          end
        end

        HIGH: begin
          if (phase_reg == '0) begin
            gen_out   <= 1'b0;
            state_reg <= LOW;
            phase_reg <= low_len_reg - PER_W'(1);
`ifdef EDGE_COUNT_EN
            neg_count <= neg_count + CNT_W'(1);
`endif
          end else begin
            phase_reg <= phase_reg - PER_W'(1);
          end
        end

        LOW: begin
          if (phase_reg != '0) begin
            phase_reg <= phase_reg - PER_W'(1);
          end else if (remaining_reg > CNT_W'(1)) begin
            gen_out       <= 1'b1;
            state_reg     <= HIGH;
            phase_reg     <= high_len_reg - PER_W'(1);
            remaining_reg <= remaining_reg - CNT_W'(1);
`ifdef EDGE_COUNT_EN
            pos_count     <= pos_count + CNT_W'(1);
`endif
          end else begin
            // Last low phase has run its full length: finish the burst.
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          gen_out   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_burst_gen.sv
// Testbench for edge_burst_gen: directed cases followed by randomized traffic.
// Accepted bursts are pushed into a scoreboard queue by the driver; a monitor
// pops them once they start and checks every cycle of the waveform against a
// closed-form description of the burst (period arithmetic on the cycle index).

module tb_edge_burst_gen;

`ifdef EDGE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] burst_len;
  logic [7:0] high_cycles;
  logic [7:0] low_cycles;
  logic       gen_out;
  logic       busy;
  logic       done;
  logic [7:0] pos_count;
  logic [7:0] neg_count;

  edge_burst_gen #(.CNT_W(8), .PER_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .burst_len   (burst_len),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .gen_out     (gen_out),
    .busy        (busy),
    .done        (done),
    .pos_count   (pos_count),
    .neg_count   (neg_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Index of the most recent rising clock edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned e0;   // edge at which start was accepted
    int          n;
    int          hp;
    int          lp;
  } burst_t;

  burst_t      sb_q[$];
  int unsigned free_at = 0;   // first edge at which a start would be accepted
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  // Apply inputs for the next rising edge, decide acceptance, then step a cycle.
  task automatic drive(input logic st, input logic [7:0] n, input logic [7:0] h,
                       input logic [7:0] l);
    int unsigned e;
    burst_t b;
    start       = st;
    burst_len   = n;
    high_cycles = h;
    low_cycles  = l;
    e = cyc + 1;
    if (st && rst_n && e >= free_at) begin
      b.e0 = e;
      b.n  = int'(n);
      b.hp = (h == 8'd0) ? 1 : int'(h);
      b.lp = (l == 8'd0) ? 1 : int'(l);
      sb_q.push_back(b);
      free_at = e + b.n * (b.hp + b.lp) + 1;
      $display("burst accepted: edge=%0d N=%0d H'=%0d L'=%0d", e, b.n, b.hp, b.lp);
    end
    @(negedge clk);
  endtask

  // Idle cycles with start low and the other inputs scrambled.
  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Monitor: checks every cycle against the active burst.
  burst_t cur;
  bit     cur_valid = 1'b0;

  always @(negedge clk) begin
    int j, p, t;
    int e_gen, e_busy, e_done, e_pos, e_neg;
    if (!rst_n) begin
      cur_valid = 1'b0;
      sb_q.delete();
      e_gen = 0; e_busy = 0; e_done = 0; e_pos = 0; e_neg = 0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].e0 <= cyc) begin
        cur = sb_q.pop_front();
        cur_valid = 1'b1;
      end
      e_gen = 0; e_busy = 0; e_done = 0; e_pos = 0; e_neg = 0;
      if (cur_valid) begin
        j = int'(cyc - cur.e0);
        p = cur.hp + cur.lp;
        t = cur.n * p;
        e_busy = (j < t) ? 1 : 0;
        e_gen  = (j < t && (j % p) < cur.hp) ? 1 : 0;
        e_done = (j == t) ? 1 : 0;
        if (cur.n > 0) begin
          e_pos = (j >= t) ? cur.n : (j / p + 1);
          e_neg = (j >= t) ? cur.n : ((j < cur.hp) ? 0 : ((j - cur.hp) / p + 1));
        end
        if (e_done == 1)
          $display("done expected: edge=%0d N=%0d gen_out=%0d pos=%0d neg=%0d",
                   cyc, cur.n, gen_out, pos_count, neg_count);
      end
    end
    if (!CNT_EN) begin
      e_pos = 0;
      e_neg = 0;
    end
    chk("gen_out",   32'(gen_out),   32'(e_gen));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
    chk("pos_count", 32'(pos_count), 32'(e_pos % 256));
    chk("neg_count", 32'(neg_count), 32'(e_neg % 256));
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    burst_len   = 8'd0;
    high_cycles = 8'd0;
    low_cycles  = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // N=5, H=1, L=1
    drive(1'b1, 8'd5, 8'd1, 8'd1);
    idle(12);
    // N=4, H=3, L=2
    drive(1'b1, 8'd4, 8'd3, 8'd2);
    idle(22);
    // Empty burst
    drive(1'b1, 8'd0, 8'd4, 8'd4);
    idle(3);
    // Zero phase lengths promoted to one
    drive(1'b1, 8'd3, 8'd0, 8'd0);
    idle(8);
    // Start on the final edge is ignored; start in the done cycle is accepted
    drive(1'b1, 8'd2, 8'd1, 8'd1);
    idle(3);
    drive(1'b1, 8'd7, 8'd2, 8'd2);
    drive(1'b1, 8'd3, 8'd2, 8'd1);
    idle(12);
    // Re-pulsed start and changing parameters mid-burst
    drive(1'b1, 8'd3, 8'd2, 8'd2);
    for (int i = 0; i < 10; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    idle(6);
    // Reset during the high phase of an N=5 burst
    drive(1'b1, 8'd5, 8'd3, 8'd3);
    idle(1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gen_out", 32'(gen_out), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_pos",     32'(pos_count), 32'd0);
    free_at = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    drive(1'b1, 8'd5, 8'd1, 8'd2);
    idle(18);
    // Long burst
    drive(1'b1, 8'd200, 8'd1, 8'd1);
    idle(405);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] n;
      n = ($urandom % 40 == 0) ? 8'($urandom_range(20, 60)) : 8'($urandom % 8);
      drive(($urandom % 6) == 0, n, 8'($urandom % 5), 8'($urandom % 5));
    end
    idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
